// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode stage: IF/ID register, 4-entry regfile, operand forwarding, ID/EX register
//
// Optional feature macro: REG0_ZERO_EN
//   defined   : R0 reads as 0, writes to R0 are dropped, and forwarding onto
//               an operand whose source ID is 0 is overridden to the regfile.
//   undefined : R0 is an ordinary register.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   if_instr, if_valid              fetched instruction and its valid flag
//   flush                           kill IF/ID and ID/EX contents
//   stall                           hold IF/ID, bubble ID/EX
//   forward_a, forward_b            operand selects: 00 regfile, 11 EX, 01 MEM, 10 WB
//   ex_fwd_data, mem_fwd_data       EX / MEM forwarding sources
//   wb_data, wb_rd, wb_reg_write    regfile write port (wb_data is also a forward source)
//   id_rs, id_rt                    decoded source IDs for the hazard unit
//   if_stall                        fetch hold, equals stall
//   ex_op_a .. ex_valid             ID/EX pipeline register outputs
module id_stage #(
    parameter int DATA_W  = 8,
    parameter int INSTR_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] if_instr,
    input  logic               if_valid,
    input  logic               flush,
    input  logic               stall,
    input  logic [1:0]         forward_a,
    input  logic [1:0]         forward_b,
    input  logic [DATA_W-1:0]  ex_fwd_data,
    input  logic [DATA_W-1:0]  mem_fwd_data,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic [1:0]         wb_rd,
    input  logic               wb_reg_write,
    output logic [1:0]         id_rs,
    output logic [1:0]         id_rt,
    output logic               if_stall,
    output logic [DATA_W-1:0]  ex_op_a,
    output logic [DATA_W-1:0]  ex_op_b,
    output logic [3:0]         ex_opcode,
    output logic [1:0]         ex_rd,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_valid
);

    logic [INSTR_W-1:0] ifid_instr;
    logic               ifid_valid;
    logic [DATA_W-1:0]  regs [4];

    logic [3:0]         dec_opcode;
    logic [1:0]         dec_rd;
    logic               dec_reg_write;
    logic               dec_mem_read;
    logic               dec_mem_write;
    logic               rf_we;
    logic [DATA_W-1:0]  rf_a;
    logic [DATA_W-1:0]  rf_b;
    logic [1:0]         sel_a;
    logic [1:0]         sel_b;
    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b;

    assign if_stall = stall;

    // IF/ID register: flush beats stall, stall holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_instr <= '0;
            ifid_valid <= 1'b0;
        end else if (flush) begin
            ifid_valid <= 1'b0;
        end else if (!stall) begin
            ifid_instr <= if_instr;
            ifid_valid <= if_valid;
        end
    end

    // Decode. An invalid slot decodes as NOP with zero source IDs, so it
    // can never raise a control bit downstream.
    always_comb begin
        dec_opcode    = 4'd0;
        dec_rd        = 2'd0;
        id_rs         = 2'd0;
        id_rt         = 2'd0;
        if (ifid_valid) begin
            dec_opcode = ifid_instr[7:4];
            dec_rd     = ifid_instr[3:2];
            id_rs      = ifid_instr[3:2];
            id_rt      = ifid_instr[1:0];
        end
        dec_reg_write = (dec_opcode >= 4'd1) && (dec_opcode <= 4'd8);
        dec_mem_read  = (dec_opcode == 4'd8);
        dec_mem_write = (dec_opcode == 4'd9);
    end

    // Register file: synchronous write, asynchronous read, no write-through.
    // A same-cycle WB hazard is resolved by the hazard unit selecting 10.
    always_comb begin
        rf_we = wb_reg_write;
        rf_a  = regs[id_rs];
        rf_b  = regs[id_rt];
        sel_a = forward_a;
        sel_b = forward_b;
`ifdef REG0_ZERO_EN
        if (wb_rd == 2'd0) rf_we = 1'b0;
        if (id_rs == 2'd0) begin
            rf_a  = '0;
            sel_a = 2'b00;
        end
        if (id_rt == 2'd0) begin
            rf_b  = '0;
            sel_b = 2'b00;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else if (rf_we) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Operand forwarding muxes.
    always_comb begin
        case (sel_a)
            2'b11:   op_a = ex_fwd_data;
            2'b01:   op_a = mem_fwd_data;
            2'b10:   op_a = wb_data;
            default: op_a = rf_a;
        endcase
        case (sel_b)
            2'b11:   op_b = ex_fwd_data;
            2'b01:   op_b = mem_fwd_data;
            2'b10:   op_b = wb_data;
            default: op_b = rf_b;
        endcase
    end

    // ID/EX register: flush or stall inserts an all-zero bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_op_a      <= '0;
            ex_op_b      <= '0;
            ex_opcode    <= 4'd0;
            ex_rd        <= 2'd0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_valid     <= 1'b0;
        end else if (flush || stall) begin
            ex_op_a      <= '0;
            ex_op_b      <= '0;
            ex_opcode    <= 4'd0;
            ex_rd        <= 2'd0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_valid     <= 1'b0;
        end else begin
            ex_op_a      <= op_a;
            ex_op_b      <= op_b;
            ex_opcode    <= dec_opcode;
            ex_rd        <= dec_rd;
            ex_reg_write <= dec_reg_write;
            ex_mem_read  <= dec_mem_read;
            ex_mem_write <= dec_mem_write;
            ex_valid     <= ifid_valid;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed self-checking bench for id_stage
module tb_id_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] if_instr;
    logic       if_valid;
    logic       flush;
    logic       stall;
    logic [1:0] forward_a;
    logic [1:0] forward_b;
    logic [7:0] ex_fwd_data;
    logic [7:0] mem_fwd_data;
    logic [7:0] wb_data;
    logic [1:0] wb_rd;
    logic       wb_reg_write;
    logic [1:0] id_rs;
    logic [1:0] id_rt;
    logic       if_stall;
    logic [7:0] ex_op_a;
    logic [7:0] ex_op_b;
    logic [3:0] ex_opcode;
    logic [1:0] ex_rd;
    logic       ex_reg_write;
    logic       ex_mem_read;
    logic       ex_mem_write;
    logic       ex_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_stage #(.DATA_W(8), .INSTR_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_instr     (if_instr),
        .if_valid     (if_valid),
        .flush        (flush),
        .stall        (stall),
        .forward_a    (forward_a),
        .forward_b    (forward_b),
        .ex_fwd_data  (ex_fwd_data),
        .mem_fwd_data (mem_fwd_data),
        .wb_data      (wb_data),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .if_stall     (if_stall),
        .ex_op_a      (ex_op_a),
        .ex_op_b      (ex_op_b),
        .ex_opcode    (ex_opcode),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_valid     (ex_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, ".valid"}, {31'd0, ex_valid}, 32'd0);
        check({tag, ".ctl"}, {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
        check({tag, ".opcode"}, {28'd0, ex_opcode}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; if_instr = 8'h00; if_valid = 1'b0; flush = 1'b0; stall = 1'b0;
        forward_a = 2'b00; forward_b = 2'b00; ex_fwd_data = 8'h00; mem_fwd_data = 8'h00;
        wb_data = 8'h00; wb_rd = 2'd0; wb_reg_write = 1'b0;
        step(); step();
        check_bubble("reset");
        check("reset.op_a", {24'd0, ex_op_a}, 32'h0);
        check("reset.rs", {30'd0, id_rs}, 32'd0);
        rst_n = 1'b1;

        // Preload R1=5, R2=7
        wb_reg_write = 1'b1; wb_rd = 2'd1; wb_data = 8'h05; step();
        wb_rd = 2'd2; wb_data = 8'h07; step();
        wb_reg_write = 1'b0;

        // ALU 0001_01_10 twice
        if_instr = 8'h16; if_valid = 1'b1; step();
        check("alu.rs", {30'd0, id_rs}, 32'd1);
        check("alu.rt", {30'd0, id_rt}, 32'd2);
        step();
        check("alu.op_a", {24'd0, ex_op_a}, 32'h05);
        check("alu.op_b", {24'd0, ex_op_b}, 32'h07);
        check("alu.rd", {30'd0, ex_rd}, 32'd1);
        check("alu.opcode", {28'd0, ex_opcode}, 32'd1);
        check("alu.ctl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'b100);
        check("alu.valid", {31'd0, ex_valid}, 32'd1);
        forward_a = 2'b11; ex_fwd_data = 8'h3C; forward_b = 2'b01; mem_fwd_data = 8'h11;
        if_valid = 1'b0; if_instr = 8'h16; step();
        check("fwd.op_a", {24'd0, ex_op_a}, 32'h3C);
        check("fwd.op_b", {24'd0, ex_op_b}, 32'h11);
        forward_a = 2'b00; forward_b = 2'b00;
        check("invalid.rs", {30'd0, id_rs}, 32'd0);
        step();
        check_bubble("invalid");

        // LOAD 1000_10_00 then one stall cycle
        if_instr = 8'h88; if_valid = 1'b1; step();
        stall = 1'b1; if_instr = 8'h16;
        #1 check("if_stall", {31'd0, if_stall}, 32'd1);
        step();
        check_bubble("stall");
        check("stall.hold_rs", {30'd0, id_rs}, 32'd2);
        stall = 1'b0; if_instr = 8'h9D; step();
        check("load.valid", {31'd0, ex_valid}, 32'd1);
        check("load.ctl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'b110);
        check("load.opcode", {28'd0, ex_opcode}, 32'd8);
        check("load.rd", {30'd0, ex_rd}, 32'd2);
        check("load.op_a", {24'd0, ex_op_a}, 32'h07);

        // STORE in IF/ID, flush and stall together
        flush = 1'b1; stall = 1'b1; step();
        check_bubble("flush");
        check("flush.ifid_rs", {30'd0, id_rs}, 32'd0);
        check("flush.ifid_rt", {30'd0, id_rt}, 32'd0);
        flush = 1'b0; stall = 1'b0; if_valid = 1'b0; step();
        check_bubble("flush.after");

        // Same-cycle WB of R3 forwarded with select 10, then regfile read
        if_instr = 8'h1C; if_valid = 1'b1; step();
        wb_reg_write = 1'b1; wb_rd = 2'd3; wb_data = 8'hAA; forward_a = 2'b10; step();
        check("wbfwd.op_a", {24'd0, ex_op_a}, 32'hAA);
        wb_reg_write = 1'b0; forward_a = 2'b00; if_instr = 8'h14; step();
        check("r3.op_a", {24'd0, ex_op_a}, 32'hAA);

        // WB to R1 with select 00 captures the old value
        wb_reg_write = 1'b1; wb_rd = 2'd1; wb_data = 8'h77; step();
        check("old.op_a", {24'd0, ex_op_a}, 32'h05);
        wb_reg_write = 1'b0; step();
        check("new.op_a", {24'd0, ex_op_a}, 32'h77);

        // R0 handling
        wb_reg_write = 1'b1; wb_rd = 2'd0; wb_data = 8'h55; if_instr = 8'h10; step();
        wb_reg_write = 1'b0; forward_a = 2'b11; ex_fwd_data = 8'h99; step();
`ifdef REG0_ZERO_EN
        check("r0.op_a", {24'd0, ex_op_a}, 32'h00);
        check("r0.op_b", {24'd0, ex_op_b}, 32'h00);
`else
        check("r0.op_a", {24'd0, ex_op_a}, 32'h99);
        check("r0.op_b", {24'd0, ex_op_b}, 32'h55);
`endif
        forward_a = 2'b00;

        // Mid-operation asynchronous reset
        check("pre_rst.valid", {31'd0, ex_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_bubble("async_rst");
        check("async_rst.rs", {30'd0, id_rs}, 32'd0);
        step();
        rst_n = 1'b1; if_instr = 8'h14; step(); step();
        check("post_rst.r1", {24'd0, ex_op_a}, 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the 4-register pipelined core, directly upstream of the EX stage and the hazard unit.
- Holds the IF/ID instruction register, the 4-entry register file, the operand forwarding muxes and the ID/EX pipeline register.
- Exports decoded source IDs to the hazard unit.
- Consumes the hazard unit's `forward_a`/`forward_b`/`stall` and inserts bubbles on stall or flush.

Parameters:
- DATA_W, 8, datapath and register width.
- INSTR_W, 8, instruction width. Fixed field map: [7:4] opcode, [3:2] rd/rs, [1:0] rt.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_instr  in  INSTR_W  fetched instruction.
- if_valid  in  1  if_instr is valid this cycle.
- flush  in  1  branch redirect; kill the IF/ID and ID/EX contents.
- stall  in  1  from the hazard unit; hold IF/ID, bubble ID/EX.
- forward_a  in  2  operand A select: 00 regfile, 11 EX, 01 MEM, 10 WB.
- forward_b  in  2  operand B select, same encoding as forward_a.
- ex_fwd_data  in  DATA_W  EX-stage ALU result.
- mem_fwd_data  in  DATA_W  MEM-stage result.
- wb_data  in  DATA_W  WB write data; also the WB forward source.
- wb_rd  in  2  WB destination register.
- wb_reg_write  in  1  WB write enable.
- id_rs  out  2  decoded rs, to the hazard unit (combinational from IF/ID).
- id_rt  out  2  decoded rt, to the hazard unit (combinational from IF/ID).
- if_stall  out  1  tells fetch to hold the PC; equals stall.
- ex_op_a  out  DATA_W  registered operand A.
- ex_op_b  out  DATA_W  registered operand B.
- ex_opcode  out  4  registered opcode.
- ex_rd  out  2  registered destination.
- ex_reg_write  out  1  registered write enable.
- ex_mem_read  out  1  registered load flag.
- ex_mem_write  out  1  registered store flag.
- ex_valid  out  1  ID/EX slot holds a real instruction.

Behaviour:
- Reset (async, rst_n=0):
  - IF/ID instruction = 0, IF/ID valid = 0.
  - All four registers = 0.
  - All ex_* outputs = 0.
  - Reset release is synchronous to the next clk edge. Reset asserted mid-operation discards all in-flight state immediately.
- Decode:
  - opcode 0000 = NOP.
  - 0001–0111 = ALU op: reg_write=1.
  - 1000 = LOAD: reg_write=1, mem_read=1.
  - 1001 = STORE: mem_write=1, reg_write=0.
  - 1010–1111 = branch/other: no write, no memory access.
  - id_rs=[3:2], id_rt=[1:0], rd=[3:2].
  - An invalid IF/ID slot decodes as NOP and drives id_rs=id_rt=0.
- Register file:
  - Written at the clk edge when wb_reg_write=1.
  - Reads are asynchronous.
  - No internal write-through: same-cycle WB hazards are covered by forward select 10.
- Operand mux: per forward_* select, choose regfile read / ex_fwd_data / mem_fwd_data / wb_data. Selects are combinational; the result is captured into ID/EX.
- Latency: one cycle from IF/ID to ex_* outputs.
- IF/ID update priority per edge:
  - flush: valid=0.
  - else stall: hold.
  - else: load if_instr/if_valid.
- ID/EX update priority per edge:
  - flush or stall: bubble. ex_valid=0; ex_reg_write, ex_mem_read, ex_mem_write = 0; ex_opcode=0; operand and ex_rd values don't-care but held at 0.
  - else: load the decoded slot. ex_valid = IF/ID valid.
- Simultaneous events:
  - flush+stall: flush wins in both registers.
  - WB write to a register being read with select 00: the old value is captured. This is legal because the hazard unit must select 10 in that case.
- Invariant: an invalid slot never asserts any ex_* control bit.

Optional Feature:
- REG0_ZERO_EN:
  - Defined: register 0 reads as 0 and writes to it are dropped.
  - Defined: a forward select other than 00 on an operand whose source ID is 0 is overridden to 00, so the operand is 0. This matches the hazard unit built with IGNORE_REG0=1.
  - Undefined: register 0 is an ordinary register.

Test Plan:
- Reset then load ALU 0001_01_10 with R1=5, R2=7 preloaded via the WB port, forward selects 00 -> next cycle ex_op_a=5, ex_op_b=7, ex_rd=1, ex_reg_write=1, ex_valid=1.
- Same instruction with forward_a=11, ex_fwd_data=0x3C, forward_b=01, mem_fwd_data=0x11 -> ex_op_a=0x3C, ex_op_b=0x11.
- LOAD 1000_10_00 followed by stall=1 for one cycle -> ex_valid=0 and all ex_* controls 0 that cycle; IF/ID held; after stall drops, the held instruction appears in ID/EX with ex_mem_read=1.
- flush=1 together with stall=1 while IF/ID holds STORE -> next cycle ex_valid=0 and IF/ID valid=0; STORE never reaches EX.
- Write R3=0xAA via WB while decoding a read of R3 with select 10, wb_data=0xAA -> ex_op_a=0xAA; next instruction reading R3 with select 00 -> 0xAA.
- REG0_ZERO_EN defined: write R0=0x55, then read R0 with forward_a=11 and ex_fwd_data=0x99 -> ex_op_a=0. Undefined: same stimulus -> ex_op_a=0x99.
